flag_branch_unit: RTL and testbench

- Consumes the zero flag and the other ALU status bits (negative, carry, overflow) and holds the architectural NZCV register.
- Resolves CBZ/CBNZ, unconditional B, and B.cond into a registered taken/resolved decision for the PC-select logic.
- Sits directly downstream of the ALU result zero-detect.
- Resolves the flag-write/B.cond hazard by same-cycle forwarding or by a one-cycle stall, chosen by a parameter.

---
 rtl/flag_branch_unit.sv | 109 ++++++++++
 tb/tb_flag_branch_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/flag_branch_unit.sv
// NZCV flag register plus branch resolver (B, CBZ/CBNZ, B.cond); decision registered one edge after acceptance.
// Flag-write/B.cond hazard is either forwarded (FORWARD=1) or stalls upstream for one cycle (FORWARD=0).
module flag_branch_unit #(
  parameter bit FORWARD = 1'b1,
  parameter int DELAY   = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       zero,
  input  logic       negative,
  input  logic       carryOut,
  input  logic       overflow,
  input  logic       setFlags,
  input  logic       brValid,
  input  logic [1:0] brType,
  input  logic       cbInvert,
  input  logic [3:0] cond,
  output logic [3:0] flags,
  output logic       brTaken,
  output logic       brResolved,
  output logic       stall
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t     state;
  logic [3:0] live_nzcv;
  logic [3:0] src_nzcv;
  logic       hazard;
  logic       accept;
  logic       idle_taken;
  logic       unused_delay;

  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] s);
    logic n, z, cf, v;
    logic r;
    n  = s[3];
    z  = s[2];
    cf = s[1];
    v  = s[0];
    case (c)
      4'b0000: r = z;
      4'b0001: r = !z;
      4'b0010: r = cf;
      4'b0011: r = !cf;
      4'b0100: r = n;
      4'b0101: r = !n;
      4'b0110: r = v;
      4'b0111: r = !v;
      4'b1000: r = cf && !z;
      4'b1001: r = !cf || z;
      4'b1010: r = (n == v);
      4'b1011: r = (n != v);
      4'b1100: r = !z && (n == v);
      4'b1101: r = z || (n != v);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  // Propagation delay only matters for gate-level models; RTL ignores it.
  assign unused_delay = (DELAY != 0);

  assign live_nzcv = {negative, zero, carryOut, overflow};
  assign src_nzcv  = (FORWARD && setFlags) ? live_nzcv : flags;
  assign accept    = brValid && (brType != 2'b00);
  assign hazard    = (state == IDLE) && brValid && (brType == 2'b11) && setFlags && !FORWARD;
  assign stall     = reset && hazard;

  always_comb begin
    idle_taken = 1'b0;
    case (brType)
      2'b01:   idle_taken = 1'b1;
      2'b10:   idle_taken = zero ^ cbInvert;
      2'b11:   idle_taken = cond_eval(cond, src_nzcv);
      default: idle_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      flags      <= 4'b0000;
      brTaken    <= 1'b0;
      brResolved <= 1'b0;
    end else begin
      brResolved <= 1'b0;
      if (setFlags) flags <= live_nzcv;
      case (state)
        IDLE: begin
          if (hazard) begin
            state <= HOLD;
          end else if (accept) begin
            brResolved <= 1'b1;
            brTaken    <= idle_taken;
          end
        end
        HOLD: begin
          // Upstream held the B.cond; evaluate against the now-updated register.
          brResolved <= 1'b1;
          brTaken    <= cond_eval(cond, flags);
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flag_branch_unit.sv
// Bench: FORWARD=0 and FORWARD=1 instances on shared stimulus, checked each cycle against a behavioural model.
module tb_flag_branch_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       zero = 1'b0, negative = 1'b0, carryOut = 1'b0, overflow = 1'b0;
  logic       setFlags = 1'b0, brValid = 1'b0, cbInvert = 1'b0;
  logic [1:0] brType = 2'b00;
  logic [3:0] cond = 4'b0000;

  logic [3:0] o_flags [2];
  logic       o_taken [2];
  logic       o_res   [2];
  logic       o_stall [2];

  int checks = 0;
  int errors = 0;

  // Index 0: FORWARD=0 (stalling), index 1: FORWARD=1 (forwarding).
  flag_branch_unit #(.FORWARD(1'b0), .DELAY(0)) u0 (
    .clk(clk), .reset(reset), .zero(zero), .negative(negative), .carryOut(carryOut),
    .overflow(overflow), .setFlags(setFlags), .brValid(brValid), .brType(brType),
    .cbInvert(cbInvert), .cond(cond), .flags(o_flags[0]), .brTaken(o_taken[0]),
    .brResolved(o_res[0]), .stall(o_stall[0])
  );

  flag_branch_unit #(.FORWARD(1'b1), .DELAY(0)) u1 (
    .clk(clk), .reset(reset), .zero(zero), .negative(negative), .carryOut(carryOut),
    .overflow(overflow), .setFlags(setFlags), .brValid(brValid), .brType(brType),
    .cbInvert(cbInvert), .cond(cond), .flags(o_flags[1]), .brTaken(o_taken[1]),
    .brResolved(o_res[1]), .stall(o_stall[1])
  );

  always #5 clk = ~clk;

  // ARM condition codes: pairs share a base test, odd code inverts it; 111x is always.
  function automatic bit model_cond(input bit [3:0] c, input bit [3:0] s);
    bit n, z, cf, v, base;
    n = s[3]; z = s[2]; cf = s[1]; v = s[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  bit [3:0] m_flags [2] = '{4'b0, 4'b0};
  bit       m_taken [2] = '{1'b0, 1'b0};
  bit       m_res   [2] = '{1'b0, 1'b0};
  bit       m_hold  [2] = '{1'b0, 1'b0};

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int f = 0; f < 2; f++) begin
        m_flags[f] = 4'b0; m_taken[f] = 1'b0; m_res[f] = 1'b0; m_hold[f] = 1'b0;
      end
    end else begin
      for (int f = 0; f < 2; f++) begin
        bit [3:0] live;
        bit       res, tk;
        live = {negative, zero, carryOut, overflow};
        res  = 1'b0;
        tk   = m_taken[f];
        if (m_hold[f]) begin
          res = 1'b1;
          tk  = model_cond(cond, m_flags[f]);
          m_hold[f] = 1'b0;
        end else if (brValid && brType != 2'b00) begin
          if (brType == 2'b11 && setFlags && f == 0) begin
            m_hold[f] = 1'b1;
          end else begin
            res = 1'b1;
            if (brType == 2'b01) tk = 1'b1;
            else if (brType == 2'b10) tk = zero ^ cbInvert;
            else tk = model_cond(cond, (setFlags && f == 1) ? live : m_flags[f]);
          end
        end
        if (setFlags) m_flags[f] = live;
        m_res[f]   = res;
        m_taken[f] = tk;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    bit exp_stall;
    exp_stall = reset && !m_hold[0] && brValid && brType == 2'b11 && setFlags;
    for (int f = 0; f < 2; f++) begin
      chk($sformatf("flags[%0d]", f), 32'(o_flags[f]), 32'(m_flags[f]));
      chk($sformatf("resolved[%0d]", f), 32'(o_res[f]), 32'(m_res[f]));
      chk($sformatf("taken[%0d]", f), 32'(o_taken[f]), 32'(m_taken[f]));
    end
    chk("stall[0]", 32'(o_stall[0]), 32'(exp_stall));
    chk("stall[1]", 32'(o_stall[1]), 32'(0));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_br(input bit v, input bit [1:0] t, input bit inv, input bit [3:0] c);
    brValid = v; brType = t; cbInvert = inv; cond = c;
  endtask

  task automatic set_alu(input bit sf, input bit n, input bit z, input bit co, input bit ov);
    setFlags = sf; negative = n; zero = z; carryOut = co; overflow = ov;
  endtask

  task automatic chk_both(input string name, input bit res, input bit tk);
    chk({name, "_res0"}, 32'(o_res[0]), 32'(res));
    chk({name, "_res1"}, 32'(o_res[1]), 32'(res));
    chk({name, "_tk0"}, 32'(o_taken[0]), 32'(tk));
    chk({name, "_tk1"}, 32'(o_taken[1]), 32'(tk));
  endtask

  initial begin
    step(); step();
    chk("rst_flags", 32'(o_flags[0]), 32'h0);
    chk("rst_res", 32'(o_res[0]), 32'h0);
    chk("rst_stall", 32'(o_stall[0]), 32'h0);
    reset = 1'b1;
    step();

    // CBZ / CBNZ with live zero; flags untouched
    set_alu(0, 0, 1, 0, 0); set_br(1, 2'b10, 0, 4'h0); step();
    chk_both("cbz", 1, 1);
    set_br(1, 2'b10, 1, 4'h0); step();
    chk_both("cbnz", 1, 0);
    chk("cb_flags", 32'(o_flags[1]), 32'h0);

    // Flag write then B.EQ / B.NE
    set_br(0, 2'b00, 0, 4'h0); set_alu(1, 0, 1, 1, 0); step();
    chk("wr_flags0", 32'(o_flags[0]), 32'h6);
    chk("wr_flags1", 32'(o_flags[1]), 32'h6);
    set_alu(0, 0, 0, 0, 0); set_br(1, 2'b11, 0, 4'b0000); step();
    chk_both("beq", 1, 1);
    set_br(1, 2'b11, 0, 4'b0001); step();
    chk_both("bne", 1, 0);

    // Signed conditions
    set_br(0, 2'b00, 0, 4'h0); set_alu(1, 1, 0, 0, 0); step();
    set_alu(0, 0, 0, 0, 0); set_br(1, 2'b11, 0, 4'b1011); step();
    chk_both("blt", 1, 1);
    set_br(1, 2'b11, 0, 4'b1100); step();
    chk_both("bgt", 1, 0);
    set_br(0, 2'b00, 0, 4'h0); set_alu(1, 1, 0, 0, 1); step();
    chk("nv_flags", 32'(o_flags[1]), 32'h9);
    set_alu(0, 0, 0, 0, 0); set_br(1, 2'b11, 0, 4'b1010); step();
    chk_both("bge", 1, 1);

    // Same-cycle hazard: forward vs stall
    set_br(0, 2'b00, 0, 4'h0); set_alu(1, 0, 0, 0, 0); step();
    set_alu(1, 0, 1, 0, 0); set_br(1, 2'b11, 0, 4'b0000); #1;
    chk("hz_stall1", 32'(o_stall[1]), 32'h0);
    chk("hz_stall0", 32'(o_stall[0]), 32'h1);
    step();
    chk("hz_res1", 32'(o_res[1]), 32'h1);
    chk("hz_tk1", 32'(o_taken[1]), 32'h1);
    chk("hz_res0", 32'(o_res[0]), 32'h0);
    chk("hz_flags0", 32'(o_flags[0]), 32'h4);
    set_alu(0, 0, 0, 0, 0); #1;
    chk("hold_stall0", 32'(o_stall[0]), 32'h0);
    step();
    chk("hold_res0", 32'(o_res[0]), 32'h1);
    chk("hold_tk0", 32'(o_taken[0]), 32'h1);

    // Throughput: B, CBZ(zero=0), B.AL
    set_br(1, 2'b01, 0, 4'h0); step();
    chk_both("tp_b", 1, 1);
    set_alu(0, 0, 0, 0, 0); set_br(1, 2'b10, 0, 4'h0); step();
    chk_both("tp_cbz", 1, 0);
    set_br(1, 2'b11, 0, 4'b1110); step();
    chk_both("tp_al", 1, 1);

    // Reset while the stalling instance is in HOLD
    set_alu(1, 1, 1, 1, 1); set_br(1, 2'b11, 0, 4'b0000); step();
    set_alu(0, 0, 0, 0, 0); #2;
    reset = 1'b0; #1;
    chk("mr_flags", 32'(o_flags[0]), 32'h0);
    chk("mr_res", 32'(o_res[0]), 32'h0);
    chk("mr_tk", 32'(o_taken[0]), 32'h0);
    set_br(0, 2'b00, 0, 4'h0); step(); step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_res", 32'(o_res[0]), 32'h0);
    end

    // Randomized traffic; hold branch fields while the stalling instance is in HOLD
    for (int i = 0; i < 2000; i++) begin
      set_alu($urandom_range(0, 3) == 0, $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 1), $urandom_range(0, 1));
      if (!m_hold[0])
        set_br($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom_range(0, 1),
               4'($urandom_range(0, 15)));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
